// File: rtl/instr_fetch_stage_if.sv
// rtl/instr_fetch_stage_if.sv - load, hazard-control and IF/ID signal bundle of the fetch stage
interface instr_fetch_stage_if #(
  parameter int AW = 5
);
  logic          LoadInstructions;
  logic [31:0]   Instruction;
  logic          Stall;
  logic          Flush;
  logic [31:0]   BranchTarget;
  logic [31:0]   IfId_Instr;
  logic [31:0]   IfId_PC4;
  logic          IfId_Valid;
  logic [AW:0]   LoadCount;
  logic          Full;
  logic          Halted;

  modport master (
    output LoadInstructions, Instruction, Stall, Flush, BranchTarget,
    input  IfId_Instr, IfId_PC4, IfId_Valid, LoadCount, Full, Halted
  );

  modport slave (
    input  LoadInstructions, Instruction, Stall, Flush, BranchTarget,
    output IfId_Instr, IfId_PC4, IfId_Valid, LoadCount, Full, Halted
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - instruction memory, serial loader, PC and IF/ID register
// Optional end-of-program halt enabled by defining IF_END_HALT_EN.
module instr_fetch_stage #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input logic                 clk,
  input logic                 Reset,
  instr_fetch_stage_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   pc4_q, pc4_d;
  logic          valid_q, valid_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [31:0]   mem [DEPTH];
  logic          mem_we;
  logic [AW-1:0] fetch_idx;
  logic          full;
`ifdef IF_END_HALT_EN
  logic          halted_q, halted_d;
  logic [AW-1:0] target_idx;
  assign target_idx = bus.BranchTarget[AW+1:2];
`endif

  assign fetch_idx = pc_q[AW+1:2];
  assign full      = (cnt_q == (AW+1)'(DEPTH));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
`ifdef IF_END_HALT_EN
    halted_d = halted_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.LoadInstructions) begin
          mem_we  = 1'b1;
          cnt_d   = cnt_q + (AW+1)'(1);
          state_d = LOAD;
        end else begin
          state_d = RUN;
        end
      end
      LOAD: begin
        if (bus.LoadInstructions) begin
          if (!full) begin
            mem_we = 1'b1;
            cnt_d  = cnt_q + (AW+1)'(1);
          end
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.Flush) begin
          pc_d    = bus.BranchTarget;
          instr_d = 32'd0;
          pc4_d   = 32'd0;
          valid_d = 1'b0;
        end else if (!bus.Stall) begin
`ifdef IF_END_HALT_EN
          // Fetching beyond the loaded program parks the stage with a NOP.
          if ({1'b0, fetch_idx} >= cnt_q) begin
            instr_d  = 32'd0;
            pc4_d    = 32'd0;
            valid_d  = 1'b0;
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            instr_d = mem[fetch_idx];
            pc4_d   = pc_q + 32'd4;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
          end
`else
          instr_d = mem[fetch_idx];
          pc4_d   = pc_q + 32'd4;
          valid_d = 1'b1;
          pc_d    = pc_q + 32'd4;
`endif
        end
      end
`ifdef IF_END_HALT_EN
      HALT: begin
        if (bus.Flush && ({1'b0, target_idx} < cnt_q)) begin
          pc_d     = bus.BranchTarget;
          halted_d = 1'b0;
          state_d  = RUN;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= 32'd0;
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
`ifdef IF_END_HALT_EN
      halted_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
`ifdef IF_END_HALT_EN
      halted_q <= halted_d;
`endif
    end
  end

  // Memory contents survive Reset; only the write is suppressed.
  always_ff @(posedge clk) begin
    if (mem_we && !Reset) begin
      mem[cnt_q[AW-1:0]] <= bus.Instruction;
    end
  end

  assign bus.IfId_Instr = instr_q;
  assign bus.IfId_PC4   = pc4_q;
  assign bus.IfId_Valid = valid_q;
  assign bus.LoadCount  = cnt_q;
  assign bus.Full       = full;
`ifdef IF_END_HALT_EN
  assign bus.Halted     = halted_q;
`else
  assign bus.Halted     = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb/tb_instr_fetch_stage.sv - directed scoreboard bench for instr_fetch_stage
module tb_instr_fetch_stage;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        halted;
  } exp_t;

  logic        clk = 1'b0;
  logic        Reset;
  exp_t        exp_q[$];
  logic [31:0] model_mem [DEPTH];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  instr_fetch_stage_if #(.AW(AW)) bus ();

  instr_fetch_stage #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ifid_valid", 32'(bus.IfId_Valid), 32'(e.valid));
      chk("ifid_instr", bus.IfId_Instr, e.valid ? e.instr : 32'd0);
      if (e.valid) chk("ifid_pc4", bus.IfId_PC4, e.pc4);
      chk("halted", 32'(bus.Halted), 32'(e.halted));
    end
  endtask

  task automatic step(input logic v, input logic [31:0] i, input logic [31:0] p4, input logic h);
    exp_t e;
    e.valid  = v;
    e.instr  = i;
    e.pc4    = p4;
    e.halted = h;
    exp_q.push_back(e);
    tick();
  endtask

  task automatic chk_reset_state();
    chk("rst_instr", bus.IfId_Instr, 32'd0);
    chk("rst_pc4", bus.IfId_PC4, 32'd0);
    chk("rst_valid", 32'(bus.IfId_Valid), 32'd0);
    chk("rst_count", 32'(bus.LoadCount), 32'd0);
    chk("rst_full", 32'(bus.Full), 32'd0);
    chk("rst_halted", 32'(bus.Halted), 32'd0);
  endtask

  initial begin
    Reset                = 1'b1;
    bus.LoadInstructions = 1'b0;
    bus.Instruction      = 32'd0;
    bus.Stall            = 1'b0;
    bus.Flush            = 1'b0;
    bus.BranchTarget     = 32'd0;
    tick();
    tick();
    chk_reset_state();
    Reset = 1'b0;

    // 33 words into a 32-deep memory: the last one must be dropped
    for (int i = 0; i < 33; i++) begin
      bus.LoadInstructions = 1'b1;
      bus.Instruction      = 32'hA500_0000 + 32'(i);
      if (i < DEPTH) model_mem[i] = bus.Instruction;
      tick();
    end
    chk("full_count", 32'(bus.LoadCount), 32'd32);
    chk("full_flag", 32'(bus.Full), 32'd1);
    bus.LoadInstructions = 1'b0;
    step(1'b0, 32'd0, 32'd0, 1'b0);
    bus.Flush        = 1'b1;
    bus.BranchTarget = 32'h7C;
    step(1'b0, 32'd0, 32'd0, 1'b0);
    bus.Flush = 1'b0;
    step(1'b1, 32'hA500_001F, 32'h80, 1'b0);
    step(1'b1, model_mem[0], 32'h84, 1'b0);

    // 11-word program
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("reload_count0", 32'(bus.LoadCount), 32'd0);
    for (int i = 0; i < 11; i++) begin
      bus.LoadInstructions = 1'b1;
      bus.Instruction      = (i == 0) ? 32'h2001_01A7 :
                             (i == 1) ? 32'h2002_005C : 32'h1000_0000 + 32'(i) * 32'h111;
      model_mem[i] = bus.Instruction;
      tick();
    end
    bus.LoadInstructions = 1'b0;
    step(1'b0, 32'd0, 32'd0, 1'b0);
    chk("prog_count", 32'(bus.LoadCount), 32'd11);
    chk("prog_full", 32'(bus.Full), 32'd0);
    step(1'b1, 32'h2001_01A7, 32'd4, 1'b0);
    step(1'b1, 32'h2002_005C, 32'd8, 1'b0);
    step(1'b1, model_mem[2], 32'd12, 1'b0);
    bus.Stall = 1'b1;
    step(1'b1, model_mem[2], 32'd12, 1'b0);
    step(1'b1, model_mem[2], 32'd12, 1'b0);
    bus.Stall = 1'b0;
    step(1'b1, model_mem[3], 32'd16, 1'b0);
    step(1'b1, model_mem[4], 32'd20, 1'b0);
    bus.Flush        = 1'b1;
    bus.BranchTarget = 32'h8;
    step(1'b0, 32'd0, 32'd0, 1'b0);
    bus.Flush = 1'b0;
    step(1'b1, model_mem[2], 32'd12, 1'b0);
    step(1'b1, model_mem[3], 32'd16, 1'b0);
    bus.Flush        = 1'b1;
    bus.Stall        = 1'b1;
    bus.BranchTarget = 32'h0;
    step(1'b0, 32'd0, 32'd0, 1'b0);
    bus.Flush = 1'b0;
    bus.Stall = 1'b0;
    step(1'b1, model_mem[0], 32'd4, 1'b0);
    for (int k = 1; k < 11; k++) begin
      step(1'b1, model_mem[k], 32'(4 * k + 4), 1'b0);
    end
`ifdef IF_END_HALT_EN
    step(1'b0, 32'd0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 32'd0, 1'b1);
    bus.Flush        = 1'b1;
    bus.BranchTarget = 32'h40;
    step(1'b0, 32'd0, 32'd0, 1'b1);
    bus.BranchTarget = 32'h0;
    step(1'b0, 32'd0, 32'd0, 1'b0);
    bus.Flush = 1'b0;
    step(1'b1, model_mem[0], 32'd4, 1'b0);
`else
    step(1'b1, model_mem[11], 32'd48, 1'b0);
    bus.Flush        = 1'b1;
    bus.BranchTarget = 32'h7C;
    step(1'b0, 32'd0, 32'd0, 1'b0);
    bus.Flush = 1'b0;
    step(1'b1, model_mem[31], 32'h80, 1'b0);
    step(1'b1, model_mem[0], 32'h84, 1'b0);
`endif

    // Reset mid-load, with LoadInstructions still high on the reset edge
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.LoadInstructions = 1'b1;
      bus.Instruction      = 32'hC000_0000 + 32'(i);
      model_mem[i] = bus.Instruction;
      tick();
    end
    Reset           = 1'b1;
    bus.Instruction = 32'hDEAD_BEEF;
    tick();
    chk_reset_state();
    Reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.Instruction = 32'hD000_0000 + 32'(i);
      model_mem[i] = bus.Instruction;
      tick();
    end
    bus.LoadInstructions = 1'b0;
    step(1'b0, 32'd0, 32'd0, 1'b0);
    chk("reload2_count", 32'(bus.LoadCount), 32'd2);
    step(1'b1, 32'hD000_0000, 32'd4, 1'b0);
    step(1'b1, 32'hD000_0001, 32'd8, 1'b0);
`ifdef IF_END_HALT_EN
    step(1'b0, 32'd0, 32'd0, 1'b1);
`else
    step(1'b1, 32'hC000_0002, 32'd12, 1'b0);
    step(1'b1, 32'hC000_0003, 32'd16, 1'b0);
    step(1'b1, model_mem[4], 32'd20, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
